// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer request bus and the FIFO write side of the
// round-robin FIFO write arbiter.
//
// Signals:
//   req_valid    [NUM_REQ]            per-producer word valid
//   req_data     [NUM_REQ*DATA_WIDTH] producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    [NUM_REQ]            per-producer accept
//   fifo_full                         FIFO full flag
//   fifo_wr_en                        FIFO write enable
//   fifo_data_in [DATA_WIDTH]         FIFO write data
//   grant_id     [$clog2(NUM_REQ)]    current owner (registered)
//   busy                              high while a grant is held
//   dbg_state                         FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a word moves from producer i when req_valid[i] and
// req_ready[i] are both high at a rising clock edge. A producer must keep
// req_valid and its data stable while valid is high and ready is low;
// ready may rise or fall without regard to valid.
//
// Modports: master = producers + FIFO side, slave = arbiter.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
    logic                          dbg_state;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, dbg_state
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, dbg_state
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One producer owns the port at a time for at most BURST_LEN accepted words;
// ownership is released early when the owner drops valid. A full FIFO
// stalls the owner without releasing it.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous reset, active low
//   bus    fifo_wr_arbiter_if.slave (request bus + FIFO write side)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_last_owner;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_busy;

    logic [ID_W-1:0]     w_base;
    logic [ID_W-1:0]     w_pick;
    logic                w_found;
    logic                w_any;
    logic                w_owner_valid;
    logic                w_wr_en;
    logic                w_last_beat;
    logic                w_release;
    logic [NUM_REQ-1:0]  w_ready;
    logic [DATA_WIDTH-1:0] w_data;

    // Round-robin search starts just after the base index and visits the
    // base itself last. In GRANT the base is the current owner, so a
    // re-arbitration on release already treats the owner as last_owner.
    always_comb begin
        w_base  = (r_state == ST_GRANT) ? r_grant_id : r_last_owner;
        w_pick  = w_base;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && bus.req_valid[(int'(w_base) + k) % NUM_REQ]) begin
                w_pick  = ID_W'((int'(w_base) + k) % NUM_REQ);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_any         = |bus.req_valid;
        w_owner_valid = bus.req_valid[r_grant_id];
        w_wr_en       = (r_state == ST_GRANT) && w_owner_valid && !bus.fifo_full;
        // Last beat of a burst: this accepted word brings the count to BURST_LEN.
        w_last_beat   = w_wr_en && (r_beat_cnt == CNT_W'(BURST_LEN - 1));
        // A full FIFO never releases; only a filled burst or a dropped valid does.
        w_release     = (r_state == ST_GRANT) && (w_last_beat || !w_owner_valid);

        w_ready = '0;
        w_data  = '0;
        if (r_state == ST_GRANT) begin
            if (!bus.fifo_full) begin
                w_ready[r_grant_id] = 1'b1;
            end
            w_data = bus.req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_last_owner <= ID_W'(NUM_REQ - 1);
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                        r_busy     <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_last_owner <= r_grant_id;
                        r_beat_cnt   <= '0;
                        if (w_any) begin
                            // Hand over in the same edge: no idle bubble.
                            r_grant_id <= w_pick;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_wr_en) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.fifo_wr_en   = w_wr_en;
    assign bus.fifo_data_in = w_data;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = r_busy;
    assign bus.dbg_state    = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (DATA_WIDTH=8, NUM_REQ=4, BURST_LEN=4).
// Producers are counters: producer i emits words 0x10*(i+1), +1, +2, ...
// and holds valid while it still has words left to send.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    localparam int DW   = 8;
    localparam int NR   = 4;
    localparam int BL   = 4;
    localparam int ID_W = $clog2(NR);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // ---------------- producers ----------------
    int             rem  [NR];
    logic [DW-1:0]  word [NR];
    logic [NR-1:0]  acc = '0;

    always @(negedge clk) acc = rst_n ? (bus.req_valid & bus.req_ready) : '0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                rem[i]--;
                word[i]++;
            end
            bus.req_valid[i]          = (rem[i] > 0);
            bus.req_data[i*DW +: DW]  = word[i];
        end
    end

    // ---------------- behavioural model ----------------
    bit started = 1'b0;
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_last  = NR - 1;

    function automatic int next_after(int base, logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(base + k) % NR]) return (base + k) % NR;
        end
        return base;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            started = 1'b1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_cnt   = 0;
            m_last  = NR - 1;
        end else if (started) begin
            if (!m_busy) begin
                if (bus.req_valid != '0) begin
                    m_owner = next_after(m_last, bus.req_valid);
                    m_cnt   = 0;
                    m_busy  = 1'b1;
                end
            end else begin
                if (bus.req_valid[m_owner] && !bus.fifo_full) m_cnt++;
                if (m_cnt == BL || !bus.req_valid[m_owner]) begin
                    m_last = m_owner;
                    m_cnt  = 0;
                    if (bus.req_valid != '0) m_owner = next_after(m_owner, bus.req_valid);
                    else                      m_busy  = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q [$];
    logic [11:0] act_q [$];
    int          cap_cyc [$];

    function automatic logic [11:0] pack(int own, int dat);
        return 12'(own * 256 + dat);
    endfunction

    task automatic expect_words(int own, int first, int n);
        for (int j = 0; j < n; j++) exp_q.push_back(pack(own, first + j));
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [NR-1:0] e_rdy;
            logic          e_wr;
            logic [DW-1:0] e_dat;
            e_rdy = (m_busy && !bus.fifo_full) ? (NR'(1) << m_owner) : '0;
            e_wr  = m_busy && bus.req_valid[m_owner] && !bus.fifo_full;
            e_dat = m_busy ? bus.req_data[m_owner*DW +: DW] : '0;
            n_vec++;
            if (bus.req_ready !== e_rdy || bus.fifo_wr_en !== e_wr ||
                bus.fifo_data_in !== e_dat || bus.grant_id !== ID_W'(m_owner) ||
                bus.busy !== m_busy || bus.dbg_state !== m_busy) begin
                n_err++;
                $display("FAIL model cyc %0d: got rdy=%b wr=%b data=%h gid=%0d busy=%b st=%b, want rdy=%b wr=%b data=%h gid=%0d busy=%b",
                         cyc, bus.req_ready, bus.fifo_wr_en, bus.fifo_data_in, bus.grant_id,
                         bus.busy, bus.dbg_state, e_rdy, e_wr, e_dat, m_owner, m_busy);
            end
            if (rst_n && bus.fifo_wr_en === 1'b1) begin
                act_q.push_back({2'b00, bus.grant_id, bus.fifo_data_in});
                cap_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(string nm);
        int k;
        repeat (3) @(posedge clk);
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        check({nm, "_idle_timeout"}, (k < 300), 1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rem(int i, int val, string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (rem[i] == val) break;
        end
        check({nm, "_rem_timeout"}, (k < 300), 1);
    endtask

    task automatic wait_grant(int g, string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && bus.grant_id === ID_W'(g)) break;
        end
        check({nm, "_grant_timeout"}, (k < 300), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) word[i] = DW'(8'h10 * (i + 1));
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;

        // Reset held two edges with all four producers valid.
        @(posedge clk);
        @(negedge clk);
        check("t1_rst_wr_en", bus.fifo_wr_en, 0);
        check("t1_rst_ready", bus.req_ready, 0);
        check("t1_rst_busy",  bus.busy, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t1_gid_after_rst",  bus.grant_id, 0);
        check("t1_busy_after_rst", bus.busy, 0);
        @(negedge clk);
        check("t1_busy_grant", bus.busy, 1);
        check("t1_wr_grant",   bus.fifo_wr_en, 1);
        check("t1_data_grant", bus.fifo_data_in, 8'h10);

        // All four valid: 0,1,2,3,0 bursts of 4 with no gaps.
        expect_words(0, 8'h10, 4);
        expect_words(1, 8'h20, 4);
        expect_words(2, 8'h30, 4);
        expect_words(3, 8'h40, 4);
        expect_words(0, 8'h14, 4);
        wait_idle("t2");
        check("t2_write_count", act_q.size(), 20);
        if (cap_cyc.size() >= 20) begin
            for (int k = 1; k < 20; k++) check("t2_no_gap", cap_cyc[k] - cap_cyc[k-1], 1);
        end

        // Lone req2: 3 words, idle, then re-granted after the IDLE cycle.
        rem[2] = 3;
        expect_words(2, 8'h34, 3);
        wait_idle("t3a");
        check("t3_idle_busy", bus.busy, 0);
        rem[2] = 2;
        expect_words(2, 8'h37, 2);
        wait_grant(2, "t3b");
        check("t3_regrant_id", bus.grant_id, 2);
        wait_idle("t3b");

        // req1 stalled by a full FIFO for 5 edges after 2 beats.
        rem[1] = 4;
        expect_words(1, 8'h24, 4);
        wait_rem(1, 2, "t4");
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_full_wr",    bus.fifo_wr_en, 0);
            check("t4_full_ready", bus.req_ready, 0);
            check("t4_full_gid",   bus.grant_id, 1);
            check("t4_full_busy",  bus.busy, 1);
        end
        @(posedge clk);
        #2 bus.fifo_full = 1'b0;
        wait_idle("t4");
        check("t4_rem_after", rem[1], 0);

        // Reset mid-burst of req3, then req1 wins from reset priority.
        rem[3] = 6;
        expect_words(3, 8'h44, 2);
        expect_words(1, 8'h28, 4);
        expect_words(3, 8'h46, 4);
        wait_rem(3, 4, "t5");
        rst_n  = 1'b0;
        rem[1] = 4;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_wr",   bus.fifo_wr_en, 0);
        @(negedge clk);
        check("t5_gid_req1", bus.grant_id, 1);
        check("t5_busy",     bus.busy, 1);
        wait_idle("t5");

        // Fairness: last owner 1, then req1+req3 -> 3, req0 joins -> 0, then 1.
        rem[1] = 1;
        expect_words(1, 8'h2c, 1);
        wait_idle("t6a");
        rem[1] = 4;
        rem[3] = 4;
        expect_words(3, 8'h4a, 4);
        expect_words(0, 8'h18, 4);
        expect_words(1, 8'h2d, 4);
        wait_grant(3, "t6");
        @(posedge clk);
        #2 rem[0] = 4;
        wait_idle("t6b");

        // Final FIFO write stream against hand-computed order.
        check("final_write_count", act_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            check($sformatf("stream_%0d", k), act_q[k], exp_q[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
